alu_z_stage: RTL and testbench
==============================

// Module: alu_z_stage
// PURPOSE
//   Result stage directly downstream of the 32-bit ALU: captures C_out_HI/C_out_LO into the ZHI/ZLO pair.
//   Sequences multi-cycle ops (mul, div) with a start/busy/done handshake to the control unit.
//   Drives the selected Z half onto the internal bus under ZHIout/ZLOout.
// PARAMETERS
//   MUL_LAT  2   cycles from start to Z load for OP_MUL (>=1)
//   DIV_LAT  32  cycles from start to Z load for OP_DIV (>=1)
//   CNT_W    6   latency counter width; must hold max(MUL_LAT,DIV_LAT)
// PORTS
//   clk        in   1   single clock, rising edge
//   clr        in   1   synchronous, active-high reset
//   start      in   1   Zin request; sampled only in IDLE
//   opcode     in   5   op being executed; latched on accepted start
//   c_hi       in   32  ALU C_out_HI
//   c_lo       in   32  ALU C_out_LO
//   zhi_out    in   1   drive ZHI onto bus
//   zlo_out    in   1   drive ZLO onto bus
//   busy       out  1   op accepted, Z not yet loaded
//   done       out  1   one-cycle pulse: Z holds new result
//   z_hi       out  32  ZHI register
//   z_lo       out  32  ZLO register
//   bus_data   out  32  Z half selected for the bus (0 when neither selected)
//   bus_drive  out  1   zhi_out | zlo_out
//   err        out  1   sticky: start seen while busy, or zhi_out&zlo_out
// BEHAVIOUR
//   - Reset (clr=1 at edge): state IDLE, cnt=0, z_hi=z_lo=0, busy=done=err=0. Overrides every other input,
//     including mid-operation; the pending op is discarded and Z is not loaded.
//   - FSM IDLE/WAIT/DONE. LAT = MUL_LAT for OP_MUL, DIV_LAT for OP_DIV, 1 for any other opcode.
//   - IDLE, start=1 at edge k: latch opcode.
//     - LAT==1: load Z from c_hi/c_lo at edge k, next state DONE.
//     - LAT>1: cnt<=LAT-1, next state WAIT.
//   - WAIT: cnt decrements each edge. At the edge where cnt==1, load Z and go to DONE.
//     Z is therefore loaded at edge k+LAT-1.
//   - DONE: done=1 for exactly this one cycle.
//     - start=0: go to IDLE.
//     - start=1: accepted exactly as in IDLE (back-to-back ops; done and the new start coincide).
//   - busy=1 in WAIT only. A start in WAIT is ignored and sets err.
//   - Control unit holds the ALU operands stable from the start edge until the Z load edge; this stage does not check it.
//   - Z retains its value in all states except at a load edge or clr.
//   - Bus selection (combinational):
//     - zlo_out=1 -> bus_data=z_lo.
//     - zhi_out=1, zlo_out=0 -> bus_data=z_hi.
//     - Both set -> bus_data=z_lo, err<=1 at next edge.
//     - Neither set -> bus_data=0, bus_drive=0.
//   - Bus read during the load edge's cycle returns the old Z (register semantics, no bypass).
//   - err clears only on clr.
// STRUCTURE
//   - Shared package: OP_ADD..OP_OR plus OP_MUL=5'b01111, OP_DIV=5'b10000; state enum IDLE/WAIT/DONE.
//     The ALU and control unit import the same opcode constants.
//   - One sub-module: z_lat_counter (load value, decrement, terminal flag).
//   - Z registers, FSM and bus mux stay inline.
// TESTING
//   1. clr: with z_hi/z_lo preloaded nonzero, clr=1 one edge -> z_hi=z_lo=0, busy=done=err=0, bus_data=0.
//   2. Add: start, opcode=00011, c_lo=0x0000_0007, c_hi=0 -> Z loaded at start edge, done next cycle;
//      zlo_out=1 -> bus_data=0x7, busy never high.
//   3. Mul, MUL_LAT=2: c_hi=0x0000_0001, c_lo=0x8000_0000 -> busy exactly 1 cycle, Z loaded at k+1;
//      zhi_out -> 0x1, zlo_out -> 0x8000_0000.
//   4. Div, DIV_LAT=32: start at edge k, extra start at k+5 -> Z loaded at k+31, second start ignored, err=1 sticky.
//   5. Div, clr at k+10 -> IDLE, Z stays 0, no done pulse.
//   6. Back-to-back: add then start=1 during DONE with sub (c_lo=0xFFFF_FFFF) -> second Z load on that edge,
//      done high two consecutive cycles; zhi_out&zlo_out -> bus_data=z_lo, err=1.

Source files
------------

// File: rtl/alu_z_stage_pkg.sv
// Opcode constants and the Z-stage state encoding.
// The ALU and the control unit import the same package.
package alu_z_stage_pkg;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } z_state_t;

    function automatic logic is_multi_cycle(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_z_stage_z_lat_counter.sv
// Latency down-counter for multi-cycle ops; term flags the final wait cycle.
module z_lat_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign term = (cnt == CNT_W'(1));

endmodule

// File: rtl/alu_z_stage.sv
// ALU result stage: ZHI/ZLO capture, mul/div latency sequencing and bus drive.
//   state | meaning
//   IDLE  | no op in flight, start accepted
//   WAIT  | multi-cycle op counting down, busy=1
//   DONE  | Z just loaded, done=1, start accepted back-to-back
module alu_z_stage #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic [31:0] c_hi,
    input  logic [31:0] c_lo,
    input  logic        zhi_out,
    input  logic        zlo_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo,
    output logic [31:0] bus_data,
    output logic        bus_drive,
    output logic        err
);

    import alu_z_stage_pkg::*;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    z_state_t         state;
    z_state_t         state_nxt;
    logic [4:0]       op_q;
    logic [CNT_W-1:0] cnt_init;
    logic [CNT_W-1:0] cnt;
    logic             cnt_term;
    logic             cnt_load;
    logic             cnt_dec;
    logic             accept;
    logic             start_multi;
    logic             wait_end;
    logic             z_load;
    logic             start_in_wait;

    // A latency of 1 yields a zero preload, which means "load Z on the start edge".
    always_comb begin
        cnt_init = '0;
        if (opcode == OP_MUL) begin
            cnt_init = MUL_CNT;
        end else if (opcode == OP_DIV) begin
            cnt_init = DIV_CNT;
        end
    end

    assign start_multi = (cnt_init != '0);
    assign accept      = start && ((state == IDLE) || (state == DONE));
    assign wait_end    = cnt_term && is_multi_cycle(op_q);
    assign cnt_dec     = (state == WAIT);

    z_lat_counter #(
        .CNT_W(CNT_W)
    ) u_lat_counter (
        .clk     (clk),
        .clr     (clr),
        .load    (cnt_load),
        .load_val(cnt_init),
        .dec     (cnt_dec),
        .cnt     (cnt),
        .term    (cnt_term)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = start_multi ? WAIT : DONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (wait_end) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        z_load        = 1'b0;
        cnt_load      = 1'b0;
        start_in_wait = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    cnt_load = start_multi;
                    z_load   = !start_multi;
                end
            end
            WAIT: begin
                busy          = 1'b1;
                z_load        = wait_end;
                start_in_wait = start;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            op_q <= '0;
        end else if (accept) begin
            op_q <= opcode;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            z_hi <= '0;
            z_lo <= '0;
        end else if (z_load) begin
            z_hi <= c_hi;
            z_lo <= c_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            err <= 1'b0;
        end else if (start_in_wait || (zhi_out && zlo_out)) begin
            err <= 1'b1;
        end
    end

    // ZLO wins when both selects collide; the collision itself is flagged via err.
    always_comb begin
        bus_data = '0;
        if (zlo_out) begin
            bus_data = z_lo;
        end else if (zhi_out) begin
            bus_data = z_hi;
        end
    end

    assign bus_drive = zhi_out | zlo_out;

endmodule

// File: tb/tb_alu_z_stage.sv
// Scoreboard bench for alu_z_stage: directed scenarios followed by random traffic.
module tb_alu_z_stage;

    import alu_z_stage_pkg::*;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 32;
    localparam int CNT_W   = 6;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [4:0]  opcode;
    logic [31:0] c_hi;
    logic [31:0] c_lo;
    logic        zhi_out;
    logic        zlo_out;
    logic        busy;
    logic        done;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic [31:0] bus_data;
    logic        bus_drive;
    logic        err;

    alu_z_stage #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .opcode   (opcode),
        .c_hi     (c_hi),
        .c_lo     (c_lo),
        .zhi_out  (zhi_out),
        .zlo_out  (zlo_out),
        .busy     (busy),
        .done     (done),
        .z_hi     (z_hi),
        .z_lo     (z_lo),
        .bus_data (bus_data),
        .bus_drive(bus_drive),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          load_edge;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          errors    = 0;
    int          checks    = 0;
    int          edge_n    = 0;
    int          last_load = 0;
    int          cur_acc   = -100;
    int          cur_load  = -100;
    bit          exp_err   = 1'b0;
    logic [31:0] m_hi      = '0;
    logic [31:0] m_lo      = '0;

    function automatic int lat_of(input logic [4:0] op);
        if (op == OP_MUL) return MUL_LAT;
        if (op == OP_DIV) return DIV_LAT;
        return 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, edge_n);
        end
    endtask

    // One clock of stimulus; the model records what the coming edge must do.
    task automatic step(input bit s, input logic [4:0] op, input logic [31:0] hi,
                        input logic [31:0] lo, input bit zh, input bit zl, input bit c);
        int t;
        int lat;
        @(negedge clk);
        t       = edge_n + 1;
        clr     = c;
        start   = s;
        opcode  = op;
        zhi_out = zh;
        zlo_out = zl;
        if (t > last_load) begin
            c_hi = hi;
            c_lo = lo;
        end
        if (c) begin
            sb.delete();
            last_load = t;
            cur_acc   = -100;
            cur_load  = -100;
            exp_err   = 1'b0;
            m_hi      = '0;
            m_lo      = '0;
        end else begin
            if (zh && zl) exp_err = 1'b1;
            if (s) begin
                if (t > last_load) begin
                    lat       = lat_of(op);
                    cur_acc   = t;
                    cur_load  = t + lat - 1;
                    last_load = cur_load;
                    sb.push_back('{cur_load, c_hi, c_lo});
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n, input bit zh, input bit zl);
        for (int i = 0; i < n; i++) step(1'b0, OP_ADD, '0, '0, zh, zl, 1'b0);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] exp_bus;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            if (sb.size() > 0 && sb[0].load_edge < edge_n) begin
                e = sb.pop_front();
                check("missed_done_edge", 32'(edge_n), 32'(e.load_edge));
                m_hi = e.hi;
                m_lo = e.lo;
            end
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'(done), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("done_edge", 32'(edge_n), 32'(e.load_edge));
                    m_hi = e.hi;
                    m_lo = e.lo;
                end
            end
            exp_bus = zlo_out ? m_lo : (zhi_out ? m_hi : 32'h0);
            check("busy", 32'(busy), 32'((edge_n >= cur_acc) && (edge_n < cur_load)));
            check("done", 32'(done), 32'(edge_n == cur_load));
            check("err", 32'(err), 32'(exp_err));
            check("z_hi", z_hi, m_hi);
            check("z_lo", z_lo, m_lo);
            check("bus_data", bus_data, exp_bus);
            check("bus_drive", 32'(bus_drive), 32'(zhi_out | zlo_out));
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : driver
        logic [4:0] ops[7];
        int         sel;
        clr     = 1'b1;
        start   = 1'b0;
        opcode  = OP_ADD;
        c_hi    = '0;
        c_lo    = '0;
        zhi_out = 1'b0;
        zlo_out = 1'b0;
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV, 5'b00000};

        step(1'b0, OP_ADD, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0, 1'b0);

        // clr after Z preloaded nonzero
        step(1'b1, OP_ADD, 32'hA5A5_0001, 32'h5A5A_0002, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1, 1'b0);
        step(1'b0, OP_ADD, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b1, 1'b0);
        idle(1, 1'b0, 1'b1);

        // single-cycle add
        step(1'b1, OP_ADD, 32'h0, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0, 1'b1);

        // mul: busy one cycle
        step(1'b1, OP_MUL, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1, 1'b0);
        idle(2, 1'b0, 1'b1);

        // div with an extra start at k+5
        step(1'b1, OP_DIV, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0, 1'b0);
        step(1'b1, OP_ADD, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        idle(30, 1'b1, 1'b0);
        idle(2, 1'b0, 1'b1);

        // div aborted by clr at k+10
        step(1'b0, OP_ADD, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, OP_DIV, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        idle(9, 1'b0, 1'b1);
        step(1'b0, OP_ADD, '0, '0, 1'b0, 1'b1, 1'b1);
        idle(35, 1'b0, 1'b1);

        // back-to-back add then sub during DONE
        step(1'b1, OP_ADD, 32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0, 1'b0);
        step(1'b1, OP_SUB, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 15);
            ops[6] = 5'($urandom);
            step($urandom_range(0, 2) == 0, ops[$urandom_range(0, 6)], $urandom, $urandom,
                 (sel == 1) || (sel == 2) || (sel == 15),
                 (sel == 3) || (sel == 4) || (sel == 15),
                 $urandom_range(0, 63) == 0);
        end
        idle(40, 1'b0, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
